command_issue_control: RTL and testbench
========================================

# command_issue_control

Command issue stage between the AFU command producers (WED fetch logic, compute units) and the PSL command interface. It buffers incoming `CommandBufferLine` entries in a FIFO and reports occupancy via `BufferStatus`; WED fetch logic gates its request on `alfull`. It issues buffered commands to the PSL under credit control, allocates PSL tags, and publishes a tag-to-command record for the response/data routing stage.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 4..256.
- `ALFULL_MARGIN`, 4: `alfull` asserts when occupancy >= `DEPTH - ALFULL_MARGIN`.
- `clock`  in  1  single clock; all logic is on its rising edge.
- `rstn_in`  in  1  reset; asynchronous, active-low. Registered once internally; the registered copy is the async reset of all state.
- `enabled_in`  in  1  AFU enable. Registered once before use.
- `croom_in`  in  8  PSL command room; sampled on the rising edge of registered enable.
- `command_in`  in  `CommandBufferLine`  command push; accepted when `.valid`.
- `credit_return_in`  in  1  one credit returned per asserted cycle (one per PSL response).
- `command_buffer_status`  out  `BufferStatus`  `{valid, empty, alfull, full}` of the FIFO.
- `cmd_valid_out`  out  1  PSL command strobe.
- `cmd_command_out`  out  13  PSL command code.
- `cmd_address_out`  out  64  effective address.
- `cmd_size_out`  out  12  transfer size in bytes.
- `cmd_tag_out`  out  8  allocated PSL tag.
- `cmd_parity_out`  out  3  odd parity of {command, address, tag}.
- `tag_record_out`  out  `CommandBufferLine`  issued entry; `.valid` set in the issue cycle, `.payload.cmd.tag` = `cmd_tag_out`.
- `overflow_out`  out  1  sticky; push attempted while full.

## Operation
- FIFO: a `command_in.valid` push writes at the write pointer when `full` is 0 in the current registered state. A pop occurs on issue. Pointers wrap modulo `DEPTH`. Occupancy counter width is clog2(DEPTH)+1.
- Push while full: dropped, `overflow_out` set; cleared only by reset. A push and a pop in the same cycle while full: the push is still dropped and the pop proceeds, so occupancy becomes `DEPTH-1`.
- Push and pop in the same cycle when not full: occupancy unchanged.
- Status is registered from occupancy: `empty` = (occ==0), `full` = (occ==DEPTH), `alfull` = (occ>=DEPTH-ALFULL_MARGIN), `valid` = ~empty.
- Credits: 8-bit counter. On the first cycle registered enable is 1 after being 0, it loads `croom_in` and no issue occurs that cycle. Each issue decrements the counter; each `credit_return_in` increments it. Simultaneous issue and return leave it unchanged. The counter saturates at the loaded croom value; an excess return is ignored.
- State machine:
  - RESET -> IDLE unconditionally.
  - IDLE -> ARMED on the enable rise, loading credits.
  - ARMED: issues when ~empty && credits>0.
  - ARMED -> IDLE when enable drops. Queued entries stay queued and credits are held.
- Issue: head entry copied to the output registers with `cmd_valid_out`=1 for exactly one cycle per command. Back-to-back issue is allowed every cycle.
- Tag: 8-bit counter, starts at 0, increments per issue, wraps 255->0.

## Timing
- Reset values:
  - all outputs 0;
  - `command_buffer_status` = {valid 0, empty 1, alfull 0, full 0};
  - credits 0, tag 0, pointers 0, state RESET.
- Latency: a push at cycle N into an empty FIFO in ARMED with credits gives `cmd_valid_out` at cycle N+2. Status reflects that push at N+1.
- Reset mid-operation clears FIFO contents, credits, and tag. Any in-flight `cmd_valid_out` drops immediately (asynchronous).
- When credits reach 0, issue stalls with no bubble penalty: the next issue occurs the cycle after a credit return.

## Configuration
- `CMD_PARITY_EN` defined: `cmd_parity_out` is registered alongside the command fields with odd parity. Bit0 covers command, bit1 covers address, bit2 covers tag.
- Undefined: `cmd_parity_out` is tied to 0 and no parity logic is instantiated.

## Test plan
- Reset release, enable with `croom_in`=8, push 3 commands at cycles 10,11,12 -> `cmd_valid_out` at 12,13,14 with tags 0,1,2; status ends empty=1.
- `croom_in`=2, push 4 commands, no returns -> only 2 issue. Pulse `credit_return_in` once -> exactly 1 more issues on the next cycle.
- `DEPTH`=16, `ALFULL_MARGIN`=4, credits 0, push 12 -> `alfull`=1 after the 12th. Push 5 more -> `full` after 16, 17th push dropped, `overflow_out`=1.
- Issue 260 commands with continuous credit returns -> the tag sequence wraps 255->0, 1.
- With `CMD_PARITY_EN`, command 0x0A00 at address 0x1 with tag 0 -> `cmd_parity_out` = {1,0,1}. Without the macro -> 0.
- Drop enable while 3 entries are queued -> issue halts, occupancy stays 3. Assert `rstn_in` mid-stream -> all outputs 0 and empty=1.

Source files
------------

// File: rtl/command_issue_control_if.sv
`default_nettype none
// ============================================================================
// Module      : command_issue_control_pkg / command_issue_control_if
// Description : Shared types for the command issue stage, plus the PSL
//               command-bus interface.
//                 master modport : issue stage (drives cmd_*, receives
//                                  croom_in and credit_return_in)
//                 slave modport  : PSL side
// Ports (if)  : cmd_valid_out, cmd_command_out[12:0], cmd_address_out[63:0],
//               cmd_size_out[11:0], cmd_tag_out[7:0], cmd_parity_out[2:0],
//               croom_in[7:0], credit_return_in
// Revision    : 1.0 - initial release
// ============================================================================
package command_issue_control_pkg;

  typedef struct packed {
    logic [12:0] command;
    logic [63:0] address;
    logic [11:0] size;
    logic [7:0]  tag;
  } CommandBufferCmd;

  typedef struct packed {
    CommandBufferCmd cmd;
  } CommandBufferPayload;

  typedef struct packed {
    logic                valid;
    CommandBufferPayload payload;
  } CommandBufferLine;

  typedef struct packed {
    logic valid;
    logic empty;
    logic alfull;
    logic full;
  } BufferStatus;

endpackage

interface command_issue_control_if;
  logic        cmd_valid_out;
  logic [12:0] cmd_command_out;
  logic [63:0] cmd_address_out;
  logic [11:0] cmd_size_out;
  logic [7:0]  cmd_tag_out;
  logic [2:0]  cmd_parity_out;
  logic [7:0]  croom_in;
  logic        credit_return_in;

  modport master (
    output cmd_valid_out, cmd_command_out, cmd_address_out,
           cmd_size_out, cmd_tag_out, cmd_parity_out,
    input  croom_in, credit_return_in
  );

  modport slave (
    input  cmd_valid_out, cmd_command_out, cmd_address_out,
           cmd_size_out, cmd_tag_out, cmd_parity_out,
    output croom_in, credit_return_in
  );
endinterface
`default_nettype wire

// File: rtl/command_issue_control.sv
`default_nettype none
// ============================================================================
// Module      : command_issue_control
// Description : Buffers CommandBufferLine entries in a FIFO, reports FIFO
//               status, and issues the buffered commands to the PSL under
//               credit control with sequential tag allocation.
// Ports       : clock                  - single rising-edge clock
//               rstn_in                - async active-low reset (registered
//                                        once, copy resets all state)
//               enabled_in             - AFU enable (registered before use)
//               command_in             - command push, taken when .valid
//               psl (master)           - PSL command bus, croom, credits
//               command_buffer_status  - {valid, empty, alfull, full}
//               tag_record_out         - issued entry with allocated tag
//               overflow_out           - sticky push-while-full flag
// Parameters  : DEPTH (power of two, 4..256), ALFULL_MARGIN
// Config      : CMD_PARITY_EN - when defined, cmd_parity_out carries odd
//               parity {tag, address, command}; otherwise tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module command_issue_control
  import command_issue_control_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int ALFULL_MARGIN = 4
) (
  input  wire logic                     clock,
  input  wire logic                     rstn_in,
  input  wire logic                     enabled_in,
  input  wire CommandBufferLine         command_in,
  command_issue_control_if.master       psl,
  output BufferStatus                   command_buffer_status,
  output CommandBufferLine              tag_record_out,
  output logic                          overflow_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ALFULL = OCC_W'(DEPTH - ALFULL_MARGIN);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ARMED = 2'd2
  } state_e;

  // Registered copy of the external reset; it asserts asynchronously with
  // rstn_in and releases on a clock edge, and is the reset for all state.
  logic rstn_q;

  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) rstn_q <= 1'b0;
    else          rstn_q <= 1'b1;
  end

  state_e              state_q,        state_d;
  logic                enabled_q,      enabled_d;
  logic                enabled_prev_q, enabled_prev_d;
  logic [PTR_W-1:0]    wr_ptr_q,       wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q,       rd_ptr_d;
  logic [OCC_W-1:0]    occ_q,          occ_d;
  BufferStatus         status_q,       status_d;
  logic [7:0]          credits_q,      credits_d;
  logic [7:0]          croom_max_q,    croom_max_d;
  logic [7:0]          tag_q,          tag_d;
  CommandBufferLine    rec_q,          rec_d;
  logic                overflow_q,     overflow_d;

  CommandBufferPayload mem_q [DEPTH];
  CommandBufferPayload head;

  logic       enable_rise;
  logic       push_ok;
  logic       push_drop;
  logic       credit_avail;
  logic       issue;
  logic       load_credits;
  logic [8:0] credit_sum;

  always_comb begin
    head         = mem_q[rd_ptr_q];
    enable_rise  = enabled_q & ~enabled_prev_q;
    push_ok      = command_in.valid && (occ_q != OCC_FULL);
    push_drop    = command_in.valid && (occ_q == OCC_FULL);

    // A return arriving this cycle funds an issue this cycle, so a credit
    // stall costs no extra bubble. Nothing is ever returned against a
    // zero croom budget.
    credit_avail = (credits_q != 8'd0) ||
                   (credit_return_in_w() && (croom_max_q != 8'd0));
    issue        = (state_q == ST_ARMED) && enabled_q &&
                   (occ_q != '0) && credit_avail;

    // FSM
    state_d      = state_q;
    load_credits = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_IDLE;
      ST_IDLE: begin
        if (enable_rise) begin
          state_d      = ST_ARMED;
          load_credits = 1'b1;
        end
      end
      ST_ARMED: begin
        if (!enabled_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    enabled_d      = enabled_in;
    enabled_prev_d = enabled_q;

    // FIFO bookkeeping; a push while full is dropped even if a pop happens
    // in the same cycle.
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(issue);
    occ_d    = occ_q + OCC_W'(push_ok) - OCC_W'(issue);

    // Status is derived from next occupancy so it moves with the push edge.
    status_d.empty  = (occ_d == '0);
    status_d.valid  = (occ_d != '0);
    status_d.full   = (occ_d == OCC_FULL);
    status_d.alfull = (occ_d >= OCC_ALFULL);

    overflow_d = overflow_q | push_drop;

    // Credits: the net change is applied first, then clamped to the loaded
    // croom so an issue plus a return at the ceiling leaves it unchanged.
    credit_sum = {1'b0, credits_q} + {8'd0, credit_return_in_w()}
               - {8'd0, issue};
    if (load_credits) begin
      credits_d   = psl.croom_in;
      croom_max_d = psl.croom_in;
    end else begin
      croom_max_d = croom_max_q;
      if (credit_sum > {1'b0, croom_max_q}) credits_d = croom_max_q;
      else                                  credits_d = credit_sum[7:0];
    end

    tag_d = tag_q + 8'(issue);

    // Issued-command register; fields hold between issues, valid pulses.
    rec_d       = rec_q;
    rec_d.valid = issue;
    if (issue) begin
      rec_d.payload         = head;
      rec_d.payload.cmd.tag = tag_q;
    end
  end

  function automatic logic credit_return_in_w();
    return psl.credit_return_in;
  endfunction

  always_ff @(posedge clock or negedge rstn_q) begin
    if (!rstn_q) begin
      state_q        <= ST_RESET;
      enabled_q      <= 1'b0;
      enabled_prev_q <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      occ_q          <= '0;
      status_q       <= '{valid: 1'b0, empty: 1'b1, alfull: 1'b0, full: 1'b0};
      credits_q      <= 8'd0;
      croom_max_q    <= 8'd0;
      tag_q          <= 8'd0;
      rec_q          <= '0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      enabled_q      <= enabled_d;
      enabled_prev_q <= enabled_prev_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      occ_q          <= occ_d;
      status_q       <= status_d;
      credits_q      <= credits_d;
      croom_max_q    <= croom_max_d;
      tag_q          <= tag_d;
      rec_q          <= rec_d;
      overflow_q     <= overflow_d;
    end
  end

  // Storage needs no reset: reset empties the FIFO through the pointers.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= command_in.payload;
  end

`ifdef CMD_PARITY_EN
  logic [2:0] parity_q, parity_d;

  // Odd parity: each bit makes its field plus the bit an odd count of ones.
  always_comb begin
    parity_d = parity_q;
    if (issue) begin
      parity_d = {~^tag_q, ~^head.cmd.address, ~^head.cmd.command};
    end
  end

  always_ff @(posedge clock or negedge rstn_q) begin
    if (!rstn_q) parity_q <= 3'b000;
    else         parity_q <= parity_d;
  end

  assign psl.cmd_parity_out = parity_q;
`else
  assign psl.cmd_parity_out = 3'b000;
`endif

  assign psl.cmd_valid_out      = rec_q.valid;
  assign psl.cmd_command_out    = rec_q.payload.cmd.command;
  assign psl.cmd_address_out    = rec_q.payload.cmd.address;
  assign psl.cmd_size_out       = rec_q.payload.cmd.size;
  assign psl.cmd_tag_out        = rec_q.payload.cmd.tag;
  assign tag_record_out         = rec_q;
  assign command_buffer_status  = status_q;
  assign overflow_out           = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_command_issue_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_command_issue_control
// Description : Self-checking bench for command_issue_control. A queue-based
//               reference model tracks pending commands, credits and tags;
//               directed scenarios plus a randomized phase are compared
//               against it every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_command_issue_control;
  import command_issue_control_pkg::*;

  localparam int DEPTH         = 16;
  localparam int ALFULL_MARGIN = 4;
`ifdef CMD_PARITY_EN
  localparam logic [2:0] PAR_0A00 = 3'b101;
`else
  localparam logic [2:0] PAR_0A00 = 3'b000;
`endif

  logic             clock      = 1'b0;
  logic             rstn_in    = 1'b1;
  logic             enabled_in = 1'b0;
  CommandBufferLine command_in = '0;
  BufferStatus      command_buffer_status;
  CommandBufferLine tag_record_out;
  logic             overflow_out;

  command_issue_control_if psl_if ();

  command_issue_control #(.DEPTH(DEPTH), .ALFULL_MARGIN(ALFULL_MARGIN)) dut (
    .clock                 (clock),
    .rstn_in               (rstn_in),
    .enabled_in            (enabled_in),
    .command_in            (command_in),
    .psl                   (psl_if),
    .command_buffer_status (command_buffer_status),
    .tag_record_out        (tag_record_out),
    .overflow_out          (overflow_out)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int seen_issues = 0;

  // ---------------- reference model ----------------
  CommandBufferCmd q[$];
  int              m_credits, m_max, m_tag, m_state; // 0 reset, 1 idle, 2 armed
  bit              m_rstq, m_en_q, m_en_prev, m_overflow;
  bit              exp_valid;
  CommandBufferCmd exp_cmd;

  task automatic model_reset();
    q.delete();
    m_credits = 0; m_max = 0; m_tag = 0; m_state = 0;
    m_rstq = 0; m_en_q = 0; m_en_prev = 0; m_overflow = 0;
    exp_valid = 0; exp_cmd = '0;
  endtask

  task automatic model_edge();
    bit rise, ret, iss, was_full;
    if (!rstn_in) begin model_reset(); return; end
    if (!m_rstq) begin m_rstq = 1; return; end
    rise     = m_en_q && !m_en_prev;
    ret      = psl_if.credit_return_in;
    iss      = (m_state == 2) && m_en_q && (q.size() > 0) &&
               (m_credits > 0 || (ret && m_max > 0));
    was_full = (q.size() == DEPTH);
    exp_valid = iss;
    if (iss) begin
      exp_cmd     = q.pop_front();
      exp_cmd.tag = 8'(m_tag);
      m_tag       = (m_tag + 1) % 256;
    end
    if (command_in.valid) begin
      if (was_full) m_overflow = 1;
      else          q.push_back(command_in.payload.cmd);
    end
    if (m_state == 1 && rise) begin
      m_credits = psl_if.croom_in;
      m_max     = psl_if.croom_in;
    end else begin
      m_credits = m_credits + int'(ret) - int'(iss);
      if (m_credits > m_max) m_credits = m_max;
    end
    case (m_state)
      0: m_state = 1;
      1: if (rise) m_state = 2;
      default: if (!m_en_q) m_state = 1;
    endcase
    m_en_prev = m_en_q;
    m_en_q    = enabled_in;
  endtask

  function automatic logic [3:0] exp_status();
    int sz = q.size();
    return {sz != 0, sz == 0, sz >= DEPTH - ALFULL_MARGIN, sz == DEPTH};
  endfunction

  function automatic logic [2:0] exp_parity(CommandBufferCmd c);
`ifdef CMD_PARITY_EN
    return {($countones(c.tag) % 2 == 0), ($countones(c.address) % 2 == 0),
            ($countones(c.command) % 2 == 0)};
`else
    return 3'b000;
`endif
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_outputs();
    chk("cmd_valid", psl_if.cmd_valid_out, exp_valid);
    chk("rec_valid", tag_record_out.valid, exp_valid);
    chk("status", command_buffer_status, exp_status());
    chk("overflow", overflow_out, m_overflow);
    if (exp_valid) begin
      chk("cmd_command", psl_if.cmd_command_out, exp_cmd.command);
      chk("cmd_address", psl_if.cmd_address_out, exp_cmd.address);
      chk("cmd_size", psl_if.cmd_size_out, exp_cmd.size);
      chk("cmd_tag", psl_if.cmd_tag_out, exp_cmd.tag);
      chk("rec_payload", tag_record_out.payload.cmd, exp_cmd);
      chk("cmd_parity", psl_if.cmd_parity_out, exp_parity(exp_cmd));
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    if (psl_if.cmd_valid_out === 1'b1) seen_issues++;
    compare_outputs();
  endtask

  task automatic set_push(input bit v);
    command_in.valid                 = v;
    command_in.payload.cmd.command   = 13'($urandom);
    command_in.payload.cmd.address   = {$urandom, $urandom};
    command_in.payload.cmd.size      = 12'($urandom);
    command_in.payload.cmd.tag       = 8'($urandom);
  endtask

  task automatic do_reset();
    rstn_in = 1'b0;
    enabled_in = 1'b0;
    command_in.valid = 1'b0;
    psl_if.credit_return_in = 1'b0;
    repeat (2) step();
    rstn_in = 1'b1;
    repeat (2) step();
  endtask

  task automatic arm(input logic [7:0] croom);
    psl_if.croom_in = croom;
    enabled_in = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    int prev_tag;
    int wrap_seen;
    bit found;
    psl_if.croom_in = 8'd0;
    psl_if.credit_return_in = 1'b0;
    model_reset();
    #1 rstn_in = 1'b0;
    repeat (3) step();
    rstn_in = 1'b1;
    repeat (2) step();
    chk("rst_status", command_buffer_status, 4'b0100);
    chk("rst_cmd_valid", psl_if.cmd_valid_out, 1'b0);
    chk("rst_overflow", overflow_out, 1'b0);
    chk("rst_record", tag_record_out, '0);

    // Three pushes, parity probe first; issues follow two cycles later.
    arm(8'd8);
    seen_issues = 0;
    set_push(1'b1);
    command_in.payload.cmd.command = 13'h0A00;
    command_in.payload.cmd.address = 64'h1;
    step();
    chk("lat_not_yet", psl_if.cmd_valid_out, 1'b0);
    set_push(1'b1);
    step();
    chk("first_tag", psl_if.cmd_tag_out, 8'd0);
    chk("parity_0a00", psl_if.cmd_parity_out, PAR_0A00);
    set_push(1'b1);
    step();
    set_push(1'b0);
    repeat (4) step();
    chk("three_issued", seen_issues, 3);
    chk("end_empty", command_buffer_status.empty, 1'b1);

    // Credit limit of 2, then a single return funds one more issue.
    enabled_in = 1'b0;
    repeat (3) step();
    arm(8'd2);
    seen_issues = 0;
    repeat (4) begin set_push(1'b1); step(); end
    set_push(1'b0);
    repeat (5) step();
    chk("credit_limited", seen_issues, 2);
    psl_if.credit_return_in = 1'b1;
    step();
    psl_if.credit_return_in = 1'b0;
    chk("return_issue", psl_if.cmd_valid_out, 1'b1);
    repeat (4) step();
    chk("credit_after_ret", seen_issues, 3);

    // Fill with no credits: alfull at 12, full at 16, 17th push dropped.
    do_reset();
    arm(8'd0);
    seen_issues = 0;
    for (int i = 1; i <= 17; i++) begin
      set_push(1'b1);
      step();
      if (i == 11) chk("alfull_11", command_buffer_status.alfull, 1'b0);
      if (i == 12) chk("alfull_12", command_buffer_status.alfull, 1'b1);
      if (i == 15) chk("full_15", command_buffer_status.full, 1'b0);
      if (i == 16) begin
        chk("full_16", command_buffer_status.full, 1'b1);
        chk("ovf_16", overflow_out, 1'b0);
      end
      if (i == 17) chk("ovf_17", overflow_out, 1'b1);
    end
    set_push(1'b0);
    psl_if.credit_return_in = 1'b1;
    repeat (2) step();
    psl_if.credit_return_in = 1'b0;
    step();
    chk("zero_croom_no_issue", seen_issues, 0);

    // Enable drop with three entries queued.
    do_reset();
    arm(8'd1);
    set_push(1'b1); step();
    set_push(1'b0); repeat (3) step();
    repeat (3) begin set_push(1'b1); step(); end
    set_push(1'b0); step();
    enabled_in = 1'b0;
    seen_issues = 0;
    repeat (4) step();
    psl_if.credit_return_in = 1'b1;
    repeat (2) step();
    psl_if.credit_return_in = 1'b0;
    repeat (4) step();
    chk("disabled_no_issue", seen_issues, 0);
    chk("disabled_queued", command_buffer_status.valid, 1'b1);
    arm(8'd3);
    repeat (6) step();
    chk("drain_after_rearm", seen_issues, 3);

    // Tag wrap with continuous pushes and returns.
    do_reset();
    arm(8'd4);
    prev_tag = -1; wrap_seen = 0; seen_issues = 0;
    psl_if.credit_return_in = 1'b1;
    for (int i = 0; i < 270; i++) begin
      set_push(1'b1);
      step();
      if (psl_if.cmd_valid_out === 1'b1) begin
        if (psl_if.cmd_tag_out == 8'd0 && prev_tag == 255) wrap_seen++;
        prev_tag = int'(psl_if.cmd_tag_out);
      end
    end
    set_push(1'b0);
    psl_if.credit_return_in = 1'b0;
    repeat (3) step();
    chk("tag_wrapped", wrap_seen, 1);
    chk("wrap_issue_count", seen_issues >= 260, 1'b1);

    // Randomized traffic.
    do_reset();
    arm(8'd3);
    for (int i = 0; i < 400; i++) begin
      set_push($urandom_range(0, 9) < 8);
      psl_if.credit_return_in = ($urandom_range(0, 9) < 3);
      psl_if.croom_in = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 39) == 0) enabled_in = ~enabled_in;
      step();
    end
    set_push(1'b0);
    psl_if.credit_return_in = 1'b0;

    // Asynchronous reset while a command is on the bus.
    enabled_in = 1'b1;
    psl_if.croom_in = 8'd5;
    psl_if.credit_return_in = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      set_push(1'b1);
      step();
      if (exp_valid) found = 1'b1;
    end
    chk("async_trigger", found, 1'b1);
    rstn_in = 1'b0;
    #1;
    model_reset();
    chk("async_valid", psl_if.cmd_valid_out, 1'b0);
    chk("async_tag", psl_if.cmd_tag_out, 8'd0);
    chk("async_cmd", psl_if.cmd_command_out, 13'd0);
    chk("async_status", command_buffer_status, 4'b0100);
    chk("async_record", tag_record_out, '0);
    chk("async_ovf", overflow_out, 1'b0);
    set_push(1'b0);
    psl_if.credit_return_in = 1'b0;
    repeat (2) step();
    rstn_in = 1'b1;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
